// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the 5-stage pipeline control: FSM states, forward selects,
// register index type.
package pipe_ctrl_pkg;

  localparam int unsigned REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    IMEM_WAIT = 2'd1,
    DMEM_WAIT = 2'd2,
    BUBBLE    = 2'd3
  } ctrl_state_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/hazard_stall_ctrl_fwd_unit.sv
// EX operand forwarding select for one source operand.
//   i_src         : source register of the EX instruction
//   i_mem_rd/_we  : destination / write enable of the MEM-stage instruction
//   i_wb_rd/_we   : destination / write enable of the WB-stage instruction
//   o_sel         : FWD_MEM, FWD_WB or FWD_RF (MEM has priority, x0 never forwarded)
module fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  reg_idx_t i_src,
  input  reg_idx_t i_mem_rd,
  input  logic     i_mem_we,
  input  reg_idx_t i_wb_rd,
  input  logic     i_wb_we,
  output fwd_sel_e o_sel
);

  logic w_mem_hit;
  logic w_wb_hit;

  assign w_mem_hit = i_mem_we && (i_mem_rd != reg_idx_t'(0)) && (i_mem_rd == i_src);
  assign w_wb_hit  = i_wb_we  && (i_wb_rd  != reg_idx_t'(0)) && (i_wb_rd  == i_src);

  always_comb begin
    o_sel = FWD_RF;
    if (w_mem_hit) begin
      o_sel = FWD_MEM;
    end else if (w_wb_hit) begin
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Central pipeline control for the 5-stage core.
//   Inputs : cache request/response handshakes, ID/EX/MEM/WB register indices,
//            write-back enables, EX mispredict, stall counter clear.
//   Outputs: per-stage load enables, ID/EX flushes, MEM_EX_rdata_hazard,
//            EX forward selects, debug FSM state, saturating stall-cycle count.
// Load/flush/forward outputs are combinational from this cycle's inputs so a
// cache response releases the stall in the same cycle.
module hazard_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   IF_mem_read,
  input  logic                   IF_mem_resp,
  input  logic                   MEM_mem_read,
  input  logic                   MEM_mem_write,
  input  logic                   MEM_mem_resp,
  input  logic [REG_IDX_W-1:0]   ID_rs1,
  input  logic [REG_IDX_W-1:0]   ID_rs2,
  input  logic [REG_IDX_W-1:0]   EX_rs1,
  input  logic [REG_IDX_W-1:0]   EX_rs2,
  input  logic [REG_IDX_W-1:0]   EX_rd,
  input  logic                   EX_mem_read,
  input  logic [REG_IDX_W-1:0]   MEM_rd,
  input  logic [REG_IDX_W-1:0]   WB_rd,
  input  logic                   MEM_regwrite,
  input  logic                   WB_regwrite,
  input  logic                   EX_mispredict,
  input  logic                   stall_clr,
  output logic                   IF_load,
  output logic                   ID_load,
  output logic                   EX_load,
  output logic                   MEM_load,
  output logic                   WB_load,
  output logic                   flush_ID,
  output logic                   flush_EX,
  output logic                   MEM_EX_rdata_hazard,
  output logic [1:0]             fwd_a_sel,
  output logic [1:0]             fwd_b_sel,
  output logic [1:0]             state,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  ctrl_state_e            r_state;
  ctrl_state_e            w_state_nxt;
  logic [STALL_CNT_W-1:0] r_stall_cycles;

  logic     w_dstall;
  logic     w_istall;
  logic     w_luse;
  logic     w_any_stall;
  fwd_sel_e w_fwd_a;
  fwd_sel_e w_fwd_b;

  // Hazard terms from this cycle's inputs
  assign w_dstall = (MEM_mem_read || MEM_mem_write) && !MEM_mem_resp;
  assign w_istall = IF_mem_read && !IF_mem_resp;
  assign w_luse   = EX_mem_read && (EX_rd != REG_IDX_W'(0)) &&
                    ((EX_rd == ID_rs1) || (EX_rd == ID_rs2));

  // Load/flush decode; priority dstall > istall > mispredict > load-use
  always_comb begin
    IF_load  = 1'b1;
    ID_load  = 1'b1;
    EX_load  = 1'b1;
    MEM_load = 1'b1;
    WB_load  = 1'b1;
    flush_ID = 1'b0;
    flush_EX = 1'b0;
    if (!reset || w_dstall || w_istall) begin
      // Whole pipe freezes; a pending mispredict stays visible on the frozen
      // EX instruction and is flushed on the first unstalled cycle.
      IF_load  = 1'b0;
      ID_load  = 1'b0;
      EX_load  = 1'b0;
      MEM_load = 1'b0;
      WB_load  = 1'b0;
    end else if (EX_mispredict) begin
      flush_ID = 1'b1;
      flush_EX = 1'b1;
    end else if (w_luse) begin
      IF_load  = 1'b0;
      ID_load  = 1'b0;
      flush_EX = 1'b1;
    end
  end

  assign MEM_EX_rdata_hazard = reset && !EX_load;
  assign w_any_stall = !(IF_load && ID_load && EX_load && MEM_load && WB_load);

  // Next state follows the same priority as the decode above
  always_comb begin
    w_state_nxt = RUN;
    if (w_dstall) begin
      w_state_nxt = DMEM_WAIT;
    end else if (w_istall) begin
      w_state_nxt = IMEM_WAIT;
    end else if (EX_mispredict) begin
      w_state_nxt = RUN;
    end else if (w_luse) begin
      w_state_nxt = BUBBLE;
    end
  end

  // State register and saturating stall counter (clear beats increment)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= RUN;
      r_stall_cycles <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (stall_clr) begin
        r_stall_cycles <= '0;
      end else if (w_any_stall && (r_stall_cycles != {STALL_CNT_W{1'b1}})) begin
        r_stall_cycles <= r_stall_cycles + STALL_CNT_W'(1);
      end
    end
  end

  assign state        = r_state;
  assign stall_cycles = r_stall_cycles;

  fwd_unit u_fwd_a (
    .i_src    (EX_rs1),
    .i_mem_rd (MEM_rd),
    .i_mem_we (MEM_regwrite),
    .i_wb_rd  (WB_rd),
    .i_wb_we  (WB_regwrite),
    .o_sel    (w_fwd_a)
  );

  fwd_unit u_fwd_b (
    .i_src    (EX_rs2),
    .i_mem_rd (MEM_rd),
    .i_mem_we (MEM_regwrite),
    .i_wb_rd  (WB_rd),
    .i_wb_we  (WB_regwrite),
    .o_sel    (w_fwd_b)
  );

  // Reset forces the selects to the register file
  assign fwd_a_sel = reset ? 2'(w_fwd_a) : 2'b00;
  assign fwd_b_sel = reset ? 2'(w_fwd_b) : 2'b00;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: single-cycle vector table plus
// multi-cycle sequences for cache misses, counter saturation and async reset.
module tb_hazard_stall_ctrl;

  localparam int unsigned CW = 4;

  logic          clk;
  logic          reset;
  logic          IF_mem_read, IF_mem_resp;
  logic          MEM_mem_read, MEM_mem_write, MEM_mem_resp;
  logic [4:0]    ID_rs1, ID_rs2, EX_rs1, EX_rs2, EX_rd, MEM_rd, WB_rd;
  logic          EX_mem_read, MEM_regwrite, WB_regwrite, EX_mispredict, stall_clr;
  logic          IF_load, ID_load, EX_load, MEM_load, WB_load;
  logic          flush_ID, flush_EX, MEM_EX_rdata_hazard;
  logic [1:0]    fwd_a_sel, fwd_b_sel, state;
  logic [CW-1:0] stall_cycles;

  int checks;
  int failures;

  hazard_stall_ctrl #(.STALL_CNT_W(CW)) dut (
    .clk                 (clk),
    .reset               (reset),
    .IF_mem_read         (IF_mem_read),
    .IF_mem_resp         (IF_mem_resp),
    .MEM_mem_read        (MEM_mem_read),
    .MEM_mem_write       (MEM_mem_write),
    .MEM_mem_resp        (MEM_mem_resp),
    .ID_rs1              (ID_rs1),
    .ID_rs2              (ID_rs2),
    .EX_rs1              (EX_rs1),
    .EX_rs2              (EX_rs2),
    .EX_rd               (EX_rd),
    .EX_mem_read         (EX_mem_read),
    .MEM_rd              (MEM_rd),
    .WB_rd               (WB_rd),
    .MEM_regwrite        (MEM_regwrite),
    .WB_regwrite         (WB_regwrite),
    .EX_mispredict       (EX_mispredict),
    .stall_clr           (stall_clr),
    .IF_load             (IF_load),
    .ID_load             (ID_load),
    .EX_load             (EX_load),
    .MEM_load            (MEM_load),
    .WB_load             (WB_load),
    .flush_ID            (flush_ID),
    .flush_EX            (flush_EX),
    .MEM_EX_rdata_hazard (MEM_EX_rdata_hazard),
    .fwd_a_sel           (fwd_a_sel),
    .fwd_b_sel           (fwd_b_sel),
    .state               (state),
    .stall_cycles        (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       imr, irs, dmr, dmw, drs;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd;
    logic       ex_mr;
    logic [4:0] mem_rd, wb_rd;
    logic       mem_rw, wb_rw, mispr;
    logic [4:0] e_loads;   // {IF,ID,EX,MEM,WB}
    logic       e_fid, e_fex, e_haz;
    logic [1:0] e_fa, e_fb, e_st;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t base();
    vec_t v;
    v = '{imr:0, irs:0, dmr:0, dmw:0, drs:0, id_rs1:0, id_rs2:0, ex_rs1:0,
          ex_rs2:0, ex_rd:0, ex_mr:0, mem_rd:0, wb_rd:0, mem_rw:0, wb_rw:0,
          mispr:0, e_loads:5'b11111, e_fid:0, e_fex:0, e_haz:0, e_fa:0,
          e_fb:0, e_st:0};
    return v;
  endfunction

  task automatic drive(input vec_t v);
    IF_mem_read   = v.imr;
    IF_mem_resp   = v.irs;
    MEM_mem_read  = v.dmr;
    MEM_mem_write = v.dmw;
    MEM_mem_resp  = v.drs;
    ID_rs1        = v.id_rs1;
    ID_rs2        = v.id_rs2;
    EX_rs1        = v.ex_rs1;
    EX_rs2        = v.ex_rs2;
    EX_rd         = v.ex_rd;
    EX_mem_read   = v.ex_mr;
    MEM_rd        = v.mem_rd;
    WB_rd         = v.wb_rd;
    MEM_regwrite  = v.mem_rw;
    WB_regwrite   = v.wb_rw;
    EX_mispredict = v.mispr;
  endtask

  function automatic logic [4:0] loads();
    return {IF_load, ID_load, EX_load, MEM_load, WB_load};
  endfunction

  // Builds the single-cycle table; every expectation derived by hand.
  task automatic build_table();
    vec_t v;
    v = base(); tbl.push_back(v);                                            // 0 idle
    v = base(); v.ex_mr = 1; v.ex_rd = 5; v.id_rs2 = 5;
    v.e_loads = 5'b00111; v.e_fex = 1; v.e_st = 3; tbl.push_back(v);         // 1 luse rs2
    v = base(); v.ex_mr = 1; v.ex_rd = 0; v.id_rs2 = 0; tbl.push_back(v);   // 2 x0 no luse
    v = base(); v.ex_mr = 1; v.ex_rd = 9; v.id_rs1 = 9;
    v.e_loads = 5'b00111; v.e_fex = 1; v.e_st = 3; tbl.push_back(v);         // 3 luse rs1
    v = base(); v.ex_rd = 9; v.id_rs1 = 9; tbl.push_back(v);                 // 4 not a load
    v = base(); v.ex_rs1 = 7; v.ex_rs2 = 7; v.mem_rd = 7; v.wb_rd = 7;
    v.mem_rw = 1; v.wb_rw = 1; v.e_fa = 2'b01; v.e_fb = 2'b01; tbl.push_back(v); // 5 MEM wins
    v = base(); v.ex_rs1 = 7; v.mem_rd = 7; v.wb_rd = 7; v.wb_rw = 1;
    v.e_fa = 2'b10; tbl.push_back(v);                                        // 6 WB fwd
    v = base(); v.mem_rw = 1; v.wb_rw = 1; tbl.push_back(v);                 // 7 x0 not fwd
    v = base(); v.ex_rs2 = 3; v.wb_rd = 3; v.wb_rw = 1; v.mem_rd = 4; v.mem_rw = 1;
    v.e_fb = 2'b10; tbl.push_back(v);                                        // 8 b from WB
    v = base(); v.dmr = 1; v.e_loads = 0; v.e_haz = 1; v.e_st = 2; tbl.push_back(v); // 9 dread miss
    v = base(); v.dmw = 1; v.e_loads = 0; v.e_haz = 1; v.e_st = 2; tbl.push_back(v); // 10 dwrite miss
    v = base(); v.dmw = 1; v.drs = 1; tbl.push_back(v);                      // 11 d resp
    v = base(); v.imr = 1; v.e_loads = 0; v.e_haz = 1; v.e_st = 1; tbl.push_back(v); // 12 i miss
    v = base(); v.imr = 1; v.irs = 1; tbl.push_back(v);                      // 13 i resp
    v = base(); v.mispr = 1; v.e_fid = 1; v.e_fex = 1; tbl.push_back(v);     // 14 mispredict
    v = base(); v.mispr = 1; v.ex_mr = 1; v.ex_rd = 6; v.id_rs1 = 6;
    v.e_fid = 1; v.e_fex = 1; tbl.push_back(v);                              // 15 mispr beats luse
    v = base(); v.dmr = 1; v.mispr = 1; v.ex_mr = 1; v.ex_rd = 6; v.id_rs1 = 6;
    v.e_loads = 0; v.e_haz = 1; v.e_st = 2; tbl.push_back(v);                // 16 dstall wins all
    v = base(); v.dmr = 1; v.imr = 1; v.e_loads = 0; v.e_haz = 1; v.e_st = 2;
    tbl.push_back(v);                                                        // 17 dstall over istall
    v = base(); v.imr = 1; v.mispr = 1; v.e_loads = 0; v.e_haz = 1; v.e_st = 1;
    tbl.push_back(v);                                                        // 18 istall over mispr
    v = base(); v.imr = 1; v.ex_mr = 1; v.ex_rd = 2; v.id_rs2 = 2;
    v.e_loads = 0; v.e_haz = 1; v.e_st = 1; tbl.push_back(v);                // 19 istall over luse
  endtask

  task automatic check_comb(input string tag, input vec_t v);
    chk({tag, " loads"}, int'(loads()), int'(v.e_loads));
    chk({tag, " flush_ID"}, int'(flush_ID), int'(v.e_fid));
    chk({tag, " flush_EX"}, int'(flush_EX), int'(v.e_fex));
    chk({tag, " hazard"}, int'(MEM_EX_rdata_hazard), int'(v.e_haz));
    chk({tag, " fwd_a"}, int'(fwd_a_sel), int'(v.e_fa));
    chk({tag, " fwd_b"}, int'(fwd_b_sel), int'(v.e_fb));
  endtask

  // Drive at posedge+1, check combinational outputs mid-cycle, state after next edge.
  task automatic step(input string tag, input vec_t v);
    drive(v);
    #2;
    check_comb(tag, v);
    @(posedge clk);
    #1;
    chk({tag, " state"}, int'(state), int'(v.e_st));
  endtask

  task automatic clear_counter();
    drive(base());
    stall_clr = 1'b1;
    @(posedge clk);
    #1;
    stall_clr = 1'b0;
    chk("stall_clr", int'(stall_cycles), 0);
  endtask

  initial begin
    vec_t v;
    checks   = 0;
    failures = 0;
    stall_clr = 1'b0;
    reset     = 1'b0;
    drive(base());
    v = base();
    v.ex_rs1 = 7; v.mem_rd = 7; v.mem_rw = 1;
    drive(v);
    #7;
    chk("reset loads", int'(loads()), 0);
    chk("reset hazard", int'(MEM_EX_rdata_hazard), 0);
    chk("reset fwd_a", int'(fwd_a_sel), 0);
    chk("reset state", int'(state), 0);
    chk("reset count", int'(stall_cycles), 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    build_table();
    foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i]);

    // D-miss: 3 waiting cycles then response
    @(posedge clk); #1;
    clear_counter();
    for (int c = 0; c < 3; c++) begin
      v = base(); v.dmr = 1; v.e_loads = 0; v.e_haz = 1; v.e_st = 2;
      step($sformatf("dmiss%0d", c), v);
    end
    v = base(); v.dmr = 1; v.drs = 1;
    step("dmiss resp", v);
    chk("dmiss count", int'(stall_cycles), 3);

    // Mispredict held during I-miss, flushed on response cycle
    for (int c = 0; c < 2; c++) begin
      v = base(); v.imr = 1; v.mispr = 1; v.e_loads = 0; v.e_haz = 1; v.e_st = 1;
      step($sformatf("imiss_mp%0d", c), v);
    end
    v = base(); v.imr = 1; v.irs = 1; v.mispr = 1; v.e_fid = 1; v.e_fex = 1;
    step("imiss_mp resp", v);

    // dstall + luse + mispredict, then response: flush applies, luse ignored
    v = base(); v.dmr = 1; v.mispr = 1; v.ex_mr = 1; v.ex_rd = 4; v.id_rs2 = 4;
    v.e_loads = 0; v.e_haz = 1; v.e_st = 2;
    step("simul stall", v);
    v.drs = 1; v.e_loads = 5'b11111; v.e_haz = 0; v.e_fid = 1; v.e_fex = 1; v.e_st = 0;
    step("simul resp", v);

    // Load-use bubble returns to RUN
    v = base(); v.ex_mr = 1; v.ex_rd = 5; v.id_rs2 = 5;
    v.e_loads = 5'b00111; v.e_fex = 1; v.e_st = 3;
    step("luse seq", v);
    step("luse after", base());

    // Saturation: 20 stall cycles on a 4-bit counter
    clear_counter();
    v = base(); v.imr = 1;
    drive(v);
    for (int c = 0; c < 20; c++) @(posedge clk);
    #1;
    chk("saturate", int'(stall_cycles), 15);
    stall_clr = 1'b1;
    @(posedge clk); #1;
    stall_clr = 1'b0;
    chk("clr over incr", int'(stall_cycles), 0);

    // Async reset in the middle of DMEM_WAIT
    v = base(); v.dmr = 1;
    drive(v);
    @(posedge clk); @(posedge clk); #1;
    chk("pre-reset state", int'(state), 2);
    chk("pre-reset count", int'(stall_cycles), 2);
    #2;
    reset = 1'b0;
    #1;
    chk("async state", int'(state), 0);
    chk("async count", int'(stall_cycles), 0);
    chk("async loads", int'(loads()), 0);
    chk("async hazard", int'(MEM_EX_rdata_hazard), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
